// File: rtl/me_pkg.sv
// Shared sizes and FSM state type for the full-search SAD engine.
package me_pkg;
  localparam int BLK       = 8;
  localparam int RANGE     = 16;
  localparam int PIX_W     = 8;
  localparam int WIN_W     = BLK + RANGE - 1;
  localparam int SAD_ROW_W = 11;
  localparam int SAD_W     = 14;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SEARCH = 2'd1,
    DRAIN  = 2'd2
  } state_t;
endpackage

// File: rtl/me_sad_row.sv
// Registered row SAD: 16 horizontal candidates of one reference row against one
// current-block row, each an 8-term absolute-difference sum.
module me_sad_row
  import me_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIN_W*PIX_W-1:0]       ref_row,
  input  logic [BLK*PIX_W-1:0]         cur_row,
  output logic [RANGE*SAD_ROW_W-1:0]   row_sad
);

  logic [RANGE*SAD_ROW_W-1:0] sad_next;

  always_comb begin
    logic [SAD_ROW_W-1:0] sum;
    logic [PIX_W-1:0]     a;
    logic [PIX_W-1:0]     b;
    sad_next = '0;
    for (int h = 0; h < RANGE; h++) begin
      sum = '0;
      for (int k = 0; k < BLK; k++) begin
        a = ref_row[(h+k)*PIX_W +: PIX_W];
        b = cur_row[k*PIX_W +: PIX_W];
        sum = sum + SAD_ROW_W'((a > b) ? (a - b) : (b - a));
      end
      sad_next[h*SAD_ROW_W +: SAD_ROW_W] = sum;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) row_sad <= '0;
    else      row_sad <= sad_next;
  end

endmodule

// File: rtl/me_sad_search.sv
// Full-search 16x16 SAD engine: loads an 8x8 current block, scores 128 streamed
// reference rows through a 4-stage pipeline and reports the best motion vector.
module me_sad_search
  import me_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [BLK*PIX_W-1:0]   cur_in,
  input  logic                   cur_valid,
  output logic                   cur_ready,
  input  logic [WIN_W*PIX_W-1:0] ref_in,
  input  logic                   ref_valid,
  output logic                   ref_ready,
  output logic [3:0]             mv_x,
  output logic [3:0]             mv_y,
  output logic [SAD_W-1:0]       min_sad,
  output logic                   result_valid,
  output logic                   busy
);

  state_t                     state;
  logic [BLK*PIX_W-1:0]       cur_mem [BLK];
  logic [2:0]                 cur_cnt;
  logic [6:0]                 row_cnt;
  logic                       cur_xfer, ref_xfer;

  logic                       in_valid;
  logic [2:0]                 in_r;
  logic [3:0]                 in_v;
  logic [WIN_W*PIX_W-1:0]     ref_q;
  logic [BLK*PIX_W-1:0]       cur_q;

  logic [RANGE*SAD_ROW_W-1:0] row_sad;
  logic                       s1_valid;
  logic [2:0]                 s1_r;
  logic [3:0]                 s1_v;

  logic [SAD_W-1:0]           acc [RANGE];
  logic                       s2_valid;
  logic [3:0]                 s2_v;

  logic [SAD_W-1:0]           tree_min;
  logic [3:0]                 tree_h;
  logic [SAD_W-1:0]           best_sad;
  logic [3:0]                 best_x, best_y;
  logic                       better, last_group;
  logic [SAD_W-1:0]           fin_sad;
  logic [3:0]                 fin_x, fin_y;

  assign cur_ready = (state == LOAD);
  assign ref_ready = (state == SEARCH);
  assign busy      = (state != LOAD);
  assign cur_xfer  = cur_valid && cur_ready;
  assign ref_xfer  = ref_valid && ref_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= LOAD;
      cur_cnt <= '0;
      row_cnt <= '0;
      for (int b = 0; b < BLK; b++) cur_mem[b] <= '0;
    end else begin
      case (state)
        LOAD: if (cur_xfer) begin
          cur_mem[cur_cnt] <= cur_in;
          cur_cnt          <= cur_cnt + 3'd1;
          if (cur_cnt == 3'd7) begin
            state   <= SEARCH;
            row_cnt <= '0;
          end
        end
        SEARCH: if (ref_xfer) begin
          row_cnt <= row_cnt + 7'd1;
          if (row_cnt == 7'd127) state <= DRAIN;
        end
        DRAIN: if (last_group) state <= LOAD;
        default: state <= LOAD;
      endcase
    end
  end

  // Capture stage: row r of group v pairs the incoming row with cur row r.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_valid <= 1'b0;
      in_r     <= '0;
      in_v     <= '0;
      ref_q    <= '0;
      cur_q    <= '0;
    end else begin
      in_valid <= ref_xfer;
      if (ref_xfer) begin
        ref_q <= ref_in;
        cur_q <= cur_mem[row_cnt[2:0]];
        in_r  <= row_cnt[2:0];
        in_v  <= row_cnt[6:3];
      end
    end
  end

  me_sad_row u_row (
    .clk     (clk),
    .rst     (rst),
    .ref_row (ref_q),
    .cur_row (cur_q),
    .row_sad (row_sad)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s1_v     <= '0;
      s2_valid <= 1'b0;
      s2_v     <= '0;
      for (int h = 0; h < RANGE; h++) acc[h] <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_r     <= in_r;
      s1_v     <= in_v;
      s2_valid <= s1_valid && (s1_r == 3'd7);
      s2_v     <= s1_v;
      if (s1_valid) begin
        for (int h = 0; h < RANGE; h++)
          acc[h] <= ((s1_r == 3'd0) ? '0 : acc[h]) +
                    SAD_W'(row_sad[h*SAD_ROW_W +: SAD_ROW_W]);
      end
    end
  end

  // Strict less-than keeps the lowest h on ties.
  always_comb begin
    tree_min = acc[0];
    tree_h   = '0;
    for (int h = 1; h < RANGE; h++) begin
      if (acc[h] < tree_min) begin
        tree_min = acc[h];
        tree_h   = 4'(h);
      end
    end
  end

  assign better     = s2_valid && (tree_min < best_sad);
  assign last_group = s2_valid && (s2_v == 4'd15);
  assign fin_sad    = better ? tree_min : best_sad;
  assign fin_x      = better ? tree_h   : best_x;
  assign fin_y      = better ? s2_v     : best_y;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      best_sad <= '1;
      best_x   <= '0;
      best_y   <= '0;
    end else if (cur_xfer && (cur_cnt == 3'd7)) begin
      best_sad <= '1;
      best_x   <= '0;
      best_y   <= '0;
    end else if (better) begin
      best_sad <= tree_min;
      best_x   <= tree_h;
      best_y   <= s2_v;
    end
  end

  // The final group's compare is folded straight into the result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mv_x         <= '0;
      mv_y         <= '0;
      min_sad      <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if ((state == DRAIN) && last_group) begin
        mv_x         <= fin_x;
        mv_y         <= fin_y;
        min_sad      <= fin_sad;
        result_valid <= 1'b1;
      end
    end
  end

endmodule
